// File: rtl/multi_project_mux_pkg.sv
// Shared definitions for the multi-project pad mux: switch-sequence states,
// register word offsets and STATUS bit positions.
package multi_project_mux_pkg;

  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2
  } sw_state_e;

  // Word offsets (byte offset >> 2) inside the 0x100-byte register window.
  localparam logic [5:0] REG_SELECT = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;

  localparam int STAT_BUSY = 8;
  localparam int STAT_PEND = 9;
  localparam int STAT_ERR  = 10;

endpackage

// File: rtl/multi_project_mux_seq.sv
// Project switch sequencer: DRAIN -> RESET (counted) -> RUN, with a one-deep
// pending request slot for selects that arrive while a switch is in progress.
module project_switch_seq
  import multi_project_mux_pkg::*;
#(
  parameter int SWITCH_RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_v,
  input  logic [7:0] req_sel,
  output sw_state_e  state,
  output logic [7:0] active,
  output logic       pend_v
);

  localparam int              CW       = $clog2(SWITCH_RST_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(SWITCH_RST_CYCLES - 1);

  sw_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_active, w_active_nxt;
  logic [7:0]    r_target, w_target_nxt;
  logic [7:0]    r_pend, w_pend_nxt;
  logic          r_pend_v, w_pend_v_nxt;
  logic [7:0]    w_sel;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_DRAIN;
      r_cnt    <= '0;
      r_active <= '0;
      r_target <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_active <= w_active_nxt;
      r_target <= w_target_nxt;
      r_pend   <= w_pend_nxt;
      r_pend_v <= w_pend_v_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_active_nxt = r_active;
    w_target_nxt = r_target;
    w_pend_nxt   = r_pend;
    w_pend_v_nxt = r_pend_v;
    w_sel        = req_sel;

    case (r_state)
      ST_DRAIN: begin
        w_active_nxt = r_target;
        w_cnt_nxt    = CNT_INIT;
        w_state_nxt  = ST_RESET;
      end
      ST_RESET: begin
        if (r_cnt == '0) w_state_nxt = ST_RUN;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: begin
        // A fresh request in the same cycle supersedes the parked one.
        w_pend_v_nxt = 1'b0;
        w_sel        = req_v ? req_sel : r_pend;
        if ((req_v || r_pend_v) && (w_sel != r_active)) begin
          w_target_nxt = w_sel;
          w_state_nxt  = ST_DRAIN;
        end
      end
    endcase

    if (req_v && (r_state != ST_RUN)) begin
      w_pend_nxt   = req_sel;
      w_pend_v_nxt = 1'b1;
    end
  end

  assign state  = r_state;
  assign active = r_active;
  assign pend_v = r_pend_v;

endmodule

// File: rtl/multi_project_mux.sv
// Selects one of NUM_PROJECTS user designs onto the IO pads under Wishbone
// control; non-active projects are held in reset with all-zero inputs.
module multi_project_mux
  import multi_project_mux_pkg::*;
#(
  parameter int          NUM_PROJECTS      = 8,
  parameter int          IO_PADS           = 38,
  parameter logic [31:0] BASE_ADDR         = 32'h3000_0000,
  parameter int          SWITCH_RST_CYCLES = 16
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_ni,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [31:0]                     wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  input  logic                            soft_rst_i,
  input  logic [IO_PADS-1:0]              io_in,
  output logic [IO_PADS-1:0]              io_out,
  output logic [IO_PADS-1:0]              io_oeb,
  output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
  input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
  input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_oeb,
  output logic [NUM_PROJECTS-1:0]         proj_rst_o,
  output logic [7:0]                      active_o
);

  localparam logic [8:0] NP9 = 9'(NUM_PROJECTS);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_err;

  sw_state_e   w_state;
  logic [7:0]  w_active;
  logic        w_pend_v;
  logic        w_run;
  logic        w_acc;
  logic [5:0]  w_off;
  logic        w_sel_wr;
  logic        w_bad;
  logic        w_req_v;
  logic        w_clr_err;
  logic [31:0] w_rdata;
  logic        w_unused;

  // The !r_ack term stops a master that holds stb through the ack cycle
  // from being accepted twice.
  assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_off     = wbs_adr_i[7:2];
  assign w_sel_wr  = w_acc & wbs_we_i & wbs_sel_i[0] & (w_off == REG_SELECT);
  assign w_bad     = {1'b0, wbs_dat_i[7:0]} >= NP9;
  assign w_req_v   = w_sel_wr & ~w_bad;
  assign w_clr_err = w_acc & wbs_we_i & (w_off == REG_STATUS) & wbs_dat_i[STAT_ERR];
  assign w_unused  = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:11], wbs_dat_i[9:8]};

  project_switch_seq #(
    .SWITCH_RST_CYCLES(SWITCH_RST_CYCLES)
  ) u_seq (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .req_v  (w_req_v),
    .req_sel(wbs_dat_i[7:0]),
    .state  (w_state),
    .active (w_active),
    .pend_v (w_pend_v)
  );

  assign w_run = (w_state == ST_RUN);

  always_comb begin
    w_rdata = '0;
    if (!wbs_we_i) begin
      case (w_off)
        REG_SELECT: w_rdata = {24'h0, w_active};
        REG_STATUS: w_rdata = {8'h0, 8'(NUM_PROJECTS), 5'h0, r_err, w_pend_v, ~w_run, w_active};
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : '0;
      if (w_sel_wr && w_bad) r_err <= 1'b1;
      else if (w_clr_err)    r_err <= 1'b0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign active_o  = w_active;

  // Pads stay released (inputs, driven low) outside RUN.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    if (w_run) begin
      for (int p = 0; p < NUM_PROJECTS; p++) begin
        if (w_active == 8'(p)) begin
          io_out = proj_io_out[p*IO_PADS +: IO_PADS];
          io_oeb = proj_io_oeb[p*IO_PADS +: IO_PADS];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PROJECTS; p++) begin : g_proj
    logic w_hit;
    assign w_hit = w_run && (w_active == 8'(p));
    assign proj_io_in[p*IO_PADS +: IO_PADS] = w_hit ? io_in : '0;
    assign proj_rst_o[p] = w_hit ? soft_rst_i : 1'b1;
  end

endmodule

// File: tb/tb_multi_project_mux.sv
// Directed bench for multi_project_mux: reset sequence, switching, error
// handling, pending selects, mid-switch reset and register-window corners.
module tb_multi_project_mux;

  localparam int          NP   = 8;
  localparam int          IOP  = 38;
  localparam int          RSTC = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_ni;
  logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              soft_rst_i;
  logic [IOP-1:0]    io_in, io_out, io_oeb;
  logic [NP*IOP-1:0] proj_io_in, proj_io_out, proj_io_oeb;
  logic [NP-1:0]     proj_rst_o;
  logic [7:0]        active_o;

  int checks = 0;
  int errors = 0;

  logic [IOP-1:0] pat_out [NP];
  logic [IOP-1:0] pat_oeb [NP];

  multi_project_mux #(
    .NUM_PROJECTS(NP), .IO_PADS(IOP), .BASE_ADDR(BASE), .SWITCH_RST_CYCLES(RSTC)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .soft_rst_i(soft_rst_i), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .proj_io_in(proj_io_in), .proj_io_out(proj_io_out), .proj_io_oeb(proj_io_oeb),
    .proj_rst_o(proj_rst_o), .active_o(active_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One Wishbone transfer; returns in the cycle the ack is observed.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit want_ack, output logic [31:0] rdata);
    bit got;
    got   = 1'b0;
    rdata = '0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        got   = 1'b1;
        rdata = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    checks++;
    if (got !== want_ack) begin
      errors++;
      $display("FAIL wb_ack adr=%h got=%0d want=%0d", adr, got, want_ack);
    end
  endtask

  // Counts consecutive sampled cycles with every project held in reset.
  task automatic count_busy(output int n);
    n = 0;
    while (proj_rst_o === 8'hFF && n < 200) begin
      n++;
      @(posedge wb_clk_i); #1;
    end
  endtask

  task automatic test_reset;
    int n;
    logic [31:0] rd;
    repeat (2) @(posedge wb_clk_i);
    #1;
    checks++;
    if (io_oeb !== '1 || io_out !== '0 || proj_rst_o !== 8'hFF) begin
      errors++;
      $display("FAIL reset_pads oeb=%h out=%h rst=%h want oeb=all1 out=0 rst=ff", io_oeb, io_out, proj_rst_o);
    end
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || active_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_wb ack=%b dat=%h act=%h want 0/0/0", wbs_ack_o, wbs_dat_o, active_o);
    end
    wb_rst_ni = 1'b1;
    count_busy(n);
    checks++;
    if (n != 17) begin errors++; $display("FAIL reset_busy_cycles got=%0d want=17", n); end
    checks++;
    if (active_o !== 8'd0 || proj_rst_o !== 8'hFE) begin
      errors++;
      $display("FAIL reset_run act=%0d rst=%h want act=0 rst=fe", active_o, proj_rst_o);
    end
    checks++;
    if (io_out !== pat_out[0] || io_oeb !== pat_oeb[0]) begin
      errors++;
      $display("FAIL reset_pads_p0 out=%h oeb=%h want out=%h oeb=%h", io_out, io_oeb, pat_out[0], pat_oeb[0]);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b1, rd);
    checks++;
    if (rd !== 32'h0008_0000) begin
      errors++;
      $display("FAIL reset_status got=%h want=00080000", rd);
    end
  endtask

  task automatic test_switch;
    int n;
    logic [31:0] rd;
    wb_xfer(1'b1, BASE, 32'h3, 4'h1, 1'b1, rd);
    checks++;
    if (io_oeb !== '1 || io_out !== '0) begin
      errors++;
      $display("FAIL switch_drain oeb=%h out=%h want all1/0", io_oeb, io_out);
    end
    count_busy(n);
    checks++;
    if (n != 17) begin errors++; $display("FAIL switch_busy_cycles got=%0d want=17", n); end
    checks++;
    if (active_o !== 8'd3 || proj_rst_o !== 8'hF7) begin
      errors++;
      $display("FAIL switch_run act=%0d rst=%h want act=3 rst=f7", active_o, proj_rst_o);
    end
    checks++;
    if (io_out !== pat_out[3] || io_oeb !== pat_oeb[3]) begin
      errors++;
      $display("FAIL switch_pads out=%h oeb=%h want out=%h oeb=%h", io_out, io_oeb, pat_out[3], pat_oeb[3]);
    end
    for (int p = 0; p < NP; p++) begin
      logic [IOP-1:0] want;
      want = (p == 3) ? io_in : '0;
      checks++;
      if (proj_io_in[p*IOP +: IOP] !== want) begin
        errors++;
        $display("FAIL switch_proj_in p=%0d got=%h want=%h", p, proj_io_in[p*IOP +: IOP], want);
      end
    end
  endtask

  task automatic test_bad_select;
    logic [31:0] rd;
    wb_xfer(1'b1, BASE, 32'h8, 4'h1, 1'b1, rd);
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b1, rd);
    checks++;
    if (rd !== 32'h0008_0403) begin
      errors++;
      $display("FAIL bad8_status got=%h want=00080403", rd);
    end
    wb_xfer(1'b1, BASE + 32'h4, 32'h400, 4'hF, 1'b1, rd);
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b1, rd);
    checks++;
    if (rd[10] !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", rd[10]); end
    wb_xfer(1'b1, BASE, 32'h9, 4'h1, 1'b1, rd);
    checks++;
    if (active_o !== 8'd3 || proj_rst_o !== 8'hF7) begin
      errors++;
      $display("FAIL bad9_noswitch act=%0d rst=%h want act=3 rst=f7", active_o, proj_rst_o);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b1, rd);
    checks++;
    if (rd !== 32'h0008_0403) begin
      errors++;
      $display("FAIL bad9_status got=%h want=00080403", rd);
    end
    wb_xfer(1'b1, BASE + 32'h4, 32'h400, 4'hF, 1'b1, rd);
  endtask

  task automatic test_pending;
    logic [31:0] rd;
    bit saw2, reached;
    int run4;
    wb_xfer(1'b1, BASE, 32'h4, 4'h1, 1'b1, rd);
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_xfer(1'b1, BASE, 32'h2, 4'h1, 1'b1, rd);
    wb_xfer(1'b1, BASE, 32'h5, 4'h1, 1'b1, rd);
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b1, rd);
    checks++;
    if (rd[9] !== 1'b1 || rd[8] !== 1'b1) begin
      errors++;
      $display("FAIL pend_status pend=%b busy=%b want 1/1", rd[9], rd[8]);
    end
    saw2 = 1'b0; reached = 1'b0; run4 = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(posedge wb_clk_i); #1;
      if (proj_rst_o === 8'hFB) saw2 = 1'b1;
      if (proj_rst_o === 8'hEF) run4++;
      if (proj_rst_o === 8'hDF) reached = 1'b1;
    end
    checks++;
    if (!reached || active_o !== 8'd5) begin
      errors++;
      $display("FAIL pend_final reached=%0d act=%0d want reached=1 act=5", reached, active_o);
    end
    checks++;
    if (saw2 || run4 != 1) begin
      errors++;
      $display("FAIL pend_order run2=%0d run4_cycles=%0d want 0/1", saw2, run4);
    end
    checks++;
    if (io_out !== pat_out[5]) begin
      errors++;
      $display("FAIL pend_pads out=%h want=%h", io_out, pat_out[5]);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b1, rd);
    checks++;
    if (rd !== 32'h0008_0005) begin
      errors++;
      $display("FAIL pend_clear_status got=%h want=00080005", rd);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [31:0] rd;
    wb_xfer(1'b1, BASE, 32'hC8, 4'h1, 1'b1, rd);
    wb_xfer(1'b1, BASE, 32'h4, 4'h1, 1'b1, rd);
    repeat (4) @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b0;
    #1;
    checks++;
    if (active_o !== 8'd0 || io_oeb !== '1 || io_out !== '0 || proj_rst_o !== 8'hFF) begin
      errors++;
      $display("FAIL midrst_async act=%0d oeb=%h out=%h rst=%h want 0/all1/0/ff", active_o, io_oeb, io_out, proj_rst_o);
    end
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1;
    count_busy(n);
    checks++;
    if (n != 17 || active_o !== 8'd0 || proj_rst_o !== 8'hFE) begin
      errors++;
      $display("FAIL midrst_recover busy=%0d act=%0d rst=%h want 17/0/fe", n, active_o, proj_rst_o);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b1, rd);
    checks++;
    if (rd !== 32'h0008_0000) begin
      errors++;
      $display("FAIL midrst_status got=%h want=00080000", rd);
    end
  endtask

  task automatic test_misc;
    logic [31:0] rd;
    wb_xfer(1'b0, BASE + 32'h80, 32'h0, 4'hF, 1'b1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h want=0", rd); end
    @(posedge wb_clk_i); #1;
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL ack_single ack=%b dat=%h want 0/0", wbs_ack_o, wbs_dat_o);
    end
    wb_xfer(1'b0, 32'h3000_0200, 32'h0, 4'hF, 1'b0, rd);
    wb_xfer(1'b1, BASE, 32'h0, 4'h1, 1'b1, rd);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (proj_rst_o !== 8'hFE || io_out !== pat_out[0]) begin
        errors++;
        $display("FAIL same_select_glitch cyc=%0d rst=%h out=%h want fe/%h", i, proj_rst_o, io_out, pat_out[0]);
      end
      @(posedge wb_clk_i); #1;
    end
    wb_xfer(1'b1, BASE, 32'h2, 4'hE, 1'b1, rd);
    @(posedge wb_clk_i); #1;
    checks++;
    if (proj_rst_o !== 8'hFE || active_o !== 8'd0) begin
      errors++;
      $display("FAIL sel0_low_ignored rst=%h act=%0d want fe/0", proj_rst_o, active_o);
    end
    soft_rst_i = 1'b1;
    #1;
    checks++;
    if (proj_rst_o !== 8'hFF || io_out !== pat_out[0]) begin
      errors++;
      $display("FAIL soft_rst_on rst=%h out=%h want ff/%h", proj_rst_o, io_out, pat_out[0]);
    end
    soft_rst_i = 1'b0;
    #1;
    checks++;
    if (proj_rst_o !== 8'hFE) begin errors++; $display("FAIL soft_rst_off rst=%h want=fe", proj_rst_o); end
  endtask

  initial begin
    wb_rst_ni  = 1'b0;
    wbs_stb_i  = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i  = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    soft_rst_i = 1'b0;
    io_in      = 38'h15_DEAD_BEEF;
    for (int p = 0; p < NP; p++) begin
      pat_out[p] = {6'(p + 1), 32'hC0DE_0000 + 32'(p * 17)};
      pat_oeb[p] = {6'h2A ^ 6'(p), 32'(p + 1) * 32'h0101_0101};
      proj_io_out[p*IOP +: IOP] = pat_out[p];
      proj_io_oeb[p*IOP +: IOP] = pat_oeb[p];
    end
    test_reset();
    test_switch();
    test_bad_select();
    test_pending();
    test_reset_mid();
    test_misc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
